// File: rtl/simple_spi_master.sv
// rtl/simple_spi_master.sv - mode-0 SPI master, one word per start, MSB first
// Every state except IDLE lasts CLKDIV cycles; all pin outputs are registered.
module simple_spi_master #(
  parameter int WIDTH  = 8,
  parameter int CLKDIV = 4
) (
  input  logic             system_clk,
  input  logic             system_reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] value_mosi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] value_miso,
  output logic             pin_ncs,
  output logic             pin_clk,
  output logic             pin_mosi,
  input  logic             pin_miso
);

  localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [BW-1:0] BIT_ALL  = BW'(WIDTH);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;

  state_t           state;
  logic [DW-1:0]    div_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] tx_sr;
  logic [WIDTH-1:0] rx_sr;
  logic             div_last;

  assign div_last = (div_cnt == DIV_LAST);

  always_ff @(posedge system_clk) begin
    if (!system_reset_n) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      value_miso <= '0;
      pin_ncs    <= 1'b1;
      pin_clk    <= 1'b0;
      pin_mosi   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE) begin
        div_cnt <= div_last ? '0 : div_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            // tx_sr holds the bits still to send, already aligned to its MSB
            state    <= SETUP;
            tx_sr    <= {value_mosi[WIDTH-2:0], 1'b0};
            rx_sr    <= '0;
            bit_cnt  <= '0;
            div_cnt  <= '0;
            pin_ncs  <= 1'b0;
            pin_mosi <= value_mosi[WIDTH-1];
            busy     <= 1'b1;
          end
        end
        SETUP: begin
          if (div_last) begin
            state   <= HIGH;
            pin_clk <= 1'b1;
          end
        end
        HIGH: begin
          if (div_last) begin
            rx_sr   <= {rx_sr[WIDTH-2:0], pin_miso};
            bit_cnt <= bit_cnt + 1'b1;
            state   <= LOW;
            pin_clk <= 1'b0;
            if (bit_cnt != BIT_LAST) begin
              pin_mosi <= tx_sr[WIDTH-1];
              tx_sr    <= {tx_sr[WIDTH-2:0], 1'b0};
            end
          end
        end
        LOW: begin
          if (div_last) begin
            if (bit_cnt == BIT_ALL) begin
              state <= HOLD;
            end else begin
              state   <= HIGH;
              pin_clk <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (div_last) begin
            state      <= GAP;
            pin_ncs    <= 1'b1;
            pin_mosi   <= 1'b0;
            done       <= 1'b1;
            value_miso <= rx_sr;
          end
        end
        GAP: begin
          if (div_last) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simple_spi_master.sv
// tb/tb_simple_spi_master.sv - directed checks of simple_spi_master
// Main instance: WIDTH=8, CLKDIV=4; second instance: WIDTH=2, CLKDIV=1 with start held.
module tb_simple_spi_master;

  logic       system_clk = 1'b0;
  logic       system_reset_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] value_mosi = 8'h00;
  logic       busy, done, pin_ncs, pin_clk, pin_mosi, pin_miso;
  logic [7:0] value_miso;

  logic       start2 = 1'b0;
  logic [1:0] value_mosi2 = 2'b10;
  logic       busy2, done2, pin_ncs2, pin_clk2, pin_mosi2;
  logic [1:0] value_miso2;

  int         miso_mode = 0;
  logic [7:0] slave_word = 8'h00;
  logic [7:0] slave_sr = 8'h00;

  int checks = 0;
  int errors = 0;

  always #5 system_clk = ~system_clk;

  simple_spi_master #(.WIDTH(8), .CLKDIV(4)) dut (
    .system_clk(system_clk), .system_reset_n(system_reset_n), .start(start),
    .value_mosi(value_mosi), .busy(busy), .done(done), .value_miso(value_miso),
    .pin_ncs(pin_ncs), .pin_clk(pin_clk), .pin_mosi(pin_mosi), .pin_miso(pin_miso)
  );

  simple_spi_master #(.WIDTH(2), .CLKDIV(1)) dut2 (
    .system_clk(system_clk), .system_reset_n(system_reset_n), .start(start2),
    .value_mosi(value_mosi2), .busy(busy2), .done(done2), .value_miso(value_miso2),
    .pin_ncs(pin_ncs2), .pin_clk(pin_clk2), .pin_mosi(pin_mosi2), .pin_miso(pin_mosi2)
  );

  assign pin_miso = (miso_mode == 0) ? pin_mosi :
                    (miso_mode == 1) ? 1'b1 :
                    (miso_mode == 2) ? 1'b0 : slave_sr[7];

  // Edge monitor and a mode-0 slave model that shifts on falling pin_clk
  int         rise_cnt = 0;
  int         rise_ncs_hi = 0;
  logic [7:0] mosi_bits = 8'h00;
  logic       prev_clk = 1'b0;

  always @(negedge system_clk) begin
    if (pin_clk && !prev_clk) begin
      rise_cnt = rise_cnt + 1;
      mosi_bits = {mosi_bits[6:0], pin_mosi};
      if (pin_ncs) rise_ncs_hi = rise_ncs_hi + 1;
    end
    if (pin_ncs) slave_sr = slave_word;
    else if (prev_clk && !pin_clk) slave_sr = {slave_sr[6:0], 1'b0};
    prev_clk = pin_clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int   ndone, done_cyc, busy_zero;
  logic ncs_c1, ncs_c72, ncs_c73;
  logic r_ncs, r_clk, r_busy, r_done;
  logic [7:0] r_miso;

  // Start cycle is cycle 0; optional start re-pulse and reset injection cycles
  task automatic xfer(input logic [7:0] w, input int inj_cyc, input logic [7:0] alt,
                      input int rst_cyc);
    rise_cnt = 0; rise_ncs_hi = 0; mosi_bits = 8'h00;
    ndone = 0; done_cyc = -1; busy_zero = -1;
    @(posedge system_clk); #1;
    start = 1'b1; value_mosi = w;
    for (int cyc = 1; cyc <= 85; cyc++) begin
      @(posedge system_clk); #1;
      start = (cyc == inj_cyc);
      if (cyc == inj_cyc) value_mosi = alt;
      system_reset_n = (cyc != rst_cyc);
      @(negedge system_clk);
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (!busy && busy_zero < 0) busy_zero = cyc;
      if (cyc == 1)  ncs_c1  = pin_ncs;
      if (cyc == 72) ncs_c72 = pin_ncs;
      if (cyc == 73) ncs_c73 = pin_ncs;
      if (cyc == rst_cyc + 1) begin
        r_ncs = pin_ncs; r_clk = pin_clk; r_busy = busy; r_done = done; r_miso = value_miso;
      end
    end
  endtask

  int   d2 [3];
  int   nd2, ncs2_hi;

  initial begin
    repeat (3) @(posedge system_clk);
    #1 system_reset_n = 1'b1;
    @(negedge system_clk);
    check("rst_ncs", pin_ncs, 1);
    check("rst_clk", pin_clk, 0);
    check("rst_mosi", pin_mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_miso", value_miso, 0);

    miso_mode = 0;
    xfer(8'hA5, -1, 8'h00, -1);
    check("lb_done_cyc", done_cyc, 73);
    check("lb_ndone", ndone, 1);
    check("lb_miso", value_miso, 8'hA5);
    check("lb_rises", rise_cnt, 8);
    check("lb_rise_ncs_hi", rise_ncs_hi, 0);
    check("lb_mosi_bits", mosi_bits, 8'hA5);
    check("lb_busy_zero", busy_zero, 77);
    check("lb_ncs_c1", ncs_c1, 0);
    check("lb_ncs_c72", ncs_c72, 0);
    check("lb_ncs_c73", ncs_c73, 1);

    miso_mode = 1;
    xfer(8'h3C, -1, 8'h00, -1);
    check("one_miso", value_miso, 8'hFF);
    check("one_mosi_bits", mosi_bits, 8'h3C);
    miso_mode = 2;
    xfer(8'h3C, -1, 8'h00, -1);
    check("zero_miso", value_miso, 8'h00);
    check("zero_rises", rise_cnt, 8);

    miso_mode = 3; slave_word = 8'h96;
    xfer(8'h4B, -1, 8'h00, -1);
    check("slv_miso", value_miso, 8'h96);
    check("slv_mosi_bits", mosi_bits, 8'h4B);

    miso_mode = 0;
    xfer(8'h5A, 10, 8'h11, -1);
    check("inj_ndone", ndone, 1);
    check("inj_miso", value_miso, 8'h5A);
    check("inj_mosi_bits", mosi_bits, 8'h5A);

    xfer(8'hE7, -1, 8'h00, 20);
    check("abort_ncs", r_ncs, 1);
    check("abort_clk", r_clk, 0);
    check("abort_busy", r_busy, 0);
    check("abort_done", r_done, 0);
    check("abort_ndone", ndone, 0);
    check("abort_miso", value_miso, 8'h00);

    xfer(8'hC3, -1, 8'h00, -1);
    check("post_rst_done_cyc", done_cyc, 73);
    check("post_rst_miso", value_miso, 8'hC3);
    repeat (10) @(posedge system_clk);
    @(negedge system_clk);
    check("hold_miso", value_miso, 8'hC3);

    // Back-to-back transfers on the WIDTH=2, CLKDIV=1 instance
    nd2 = 0; ncs2_hi = 0;
    d2[0] = -1; d2[1] = -1; d2[2] = -1;
    @(posedge system_clk); #1 start2 = 1'b1;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      @(posedge system_clk); #1;
      if (cyc == 23) start2 = 1'b0;
      @(negedge system_clk);
      if (done2) begin
        if (nd2 < 3) d2[nd2] = cyc;
        nd2++;
      end
      if (cyc >= 2 && cyc <= 14 && pin_ncs2) ncs2_hi++;
    end
    check("b2b_done0", d2[0], 7);
    check("b2b_done1", d2[1], 15);
    check("b2b_done2", d2[2], 23);
    check("b2b_ndone", nd2, 3);
    check("b2b_ncs_gap", ncs2_hi, 2);
    check("b2b_miso", value_miso2, 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/simple_spi_master.md
SIMPLE_SPI_MASTER -- requirements
Module: simple_spi_master

Interface
REQ-001 Parameters SHALL be:
- WIDTH, default 8: bits per transfer; legal values are 2 or more.
- CLKDIV, default 4: system_clk cycles per SPI half-period; legal values are 1 or more, and 4 or more when driving simple_spi_slave on the same clock.

REQ-002 Ports SHALL be:
- system_clk  in  1: the single clock; all logic is on its rising edge.
- system_reset_n  in  1: synchronous, active-low reset.
- start  in  1: transfer request.
- value_mosi  in  WIDTH: word to transmit, MSB first.
- busy  out  1: a transfer or the deselect gap is in progress.
- done  out  1: one-cycle pulse at transfer end.
- value_miso  out  WIDTH: last received word.
- pin_ncs  out  1: chip select, active low.
- pin_clk  out  1: SPI clock.
- pin_mosi  out  1: serial data out.
- pin_miso  in  1: serial data in.

REQ-003 The block SHALL use one clock with a synchronous, active-low reset, named system_clk and system_reset_n.

Function
REQ-004 SPI mode SHALL be mode 0 (CPOL=0, CPHA=0): pin_clk idles low; data is shifted out on falling edges and captured on rising edges.

REQ-005 The FSM SHALL have the states IDLE, SETUP, HIGH, LOW, HOLD and GAP. Each state other than IDLE SHALL last exactly CLKDIV cycles.

REQ-006 IDLE behaviour:
- Outputs: pin_ncs=1, pin_clk=0, pin_mosi=0, busy=0.
- If start=1, the FSM SHALL latch value_mosi into the shift register and enter SETUP on the next cycle.

REQ-007 SETUP behaviour: pin_ncs=0, pin_clk=0, pin_mosi=bit WIDTH-1. Then go to HIGH.

REQ-008 HIGH behaviour: pin_clk=1 throughout. In the last cycle of HIGH, pin_miso SHALL be shifted into the receive register LSB, with earlier bits moving toward the MSB. Then go to LOW.

REQ-009 LOW behaviour: pin_clk=0, and pin_mosi presents the next bit from the first cycle of LOW.
- If bits remain, go to HIGH.
- After the WIDTH-th bit, go to HOLD.

REQ-010 HOLD behaviour: pin_ncs=0, pin_clk=0, pin_mosi holds its value.

REQ-011 On HOLD exit:
- pin_ncs SHALL rise.
- done SHALL pulse for exactly 1 cycle.
- value_miso SHALL be updated with the received word in the same cycle.
- The FSM enters GAP.

REQ-012 GAP behaviour: pin_ncs=1, pin_clk=0, busy=1. Then go to IDLE.

REQ-013 busy SHALL be 1 from the cycle after an accepted start through the last GAP cycle, inclusive.

REQ-014 Timing, with the start cycle as cycle 0:
- pin_ncs SHALL be low for cycles 1 .. CLKDIV*(2*WIDTH+2).
- done SHALL pulse in cycle CLKDIV*(2*WIDTH+2)+1.
- busy SHALL be 0 again in cycle CLKDIV*(2*WIDTH+3)+1.

REQ-015 pin_clk SHALL produce exactly WIDTH rising edges per transfer, and none while pin_ncs=1.

REQ-016 start SHALL be ignored while busy=1. value_mosi SHALL be sampled only on an accepted start, so changes during a transfer have no effect.

REQ-017 start held high continuously SHALL produce back-to-back transfers, each separated by the full GAP.

REQ-018 value_miso SHALL hold its value between done pulses.

REQ-019 The half-period counter SHALL be ceil(log2(CLKDIV)) bits wide, minimum 1. The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide.

Reset
REQ-020 While system_reset_n=0 at a clock edge, the next cycle SHALL have:
- FSM in IDLE;
- pin_ncs=1, pin_clk=0, pin_mosi=0;
- busy=0, done=0;
- value_miso=0;
- all counters and shift registers cleared.

REQ-021 Reset mid-transfer SHALL abort the transfer immediately. It SHALL produce no done pulse and leave value_miso=0.

REQ-022 A start that coincides with reset asserted SHALL be ignored.

Verification
REQ-023 Loopback (pin_miso=pin_mosi), WIDTH=8, CLKDIV=4, start with value_mosi=0xA5 -> done after 73 cycles, value_miso=0xA5, 8 pin_clk rising edges.

REQ-024 pin_miso tied to 1, then tied to 0, value_mosi=0x3C -> value_miso=0xFF, then 0x00. The pin_mosi bit sequence sampled at pin_clk rising edges SHALL be 0,0,1,1,1,1,0,0.

REQ-025 Master connected to simple_spi_slave (WIDTH=4, CLKDIV=4), master value_mosi=4'b0110, slave value_miso=4'b1010 -> slave value_valid once with value_mosi=4'b0110, master value_miso=4'b1010. Repeat for all 16x16 pairs.

REQ-026 start pulsed again at cycle 10 of a transfer with a different value_mosi -> ignored. Exactly one done pulse occurs, and the first word is transmitted.

REQ-027 system_reset_n driven low at cycle 20 of a transfer -> the next cycle shows pin_ncs=1, pin_clk=0, busy=0, with no done and value_miso=0. A new start is then accepted normally.

REQ-028 start held high for 3 transfers, CLKDIV=1, WIDTH=2 -> done pulses at cycles 7, 15 and 23. pin_ncs SHALL be high for exactly 2 cycles between transfers.
